// File: rtl/id_stage_buf.sv
// ---------------------------------------------------------------------------
// id_stage_buf
//   Buffered instruction-decode stage between IF_ID and ID_EX.
//   Fetched instructions are queued in an IBUF_DEPTH-entry FIFO. The head
//   entry is decoded combinationally and loaded into the ID output register.
//   Load-use hazards against the output register insert bubbles, which are
//   counted in a saturating counter.
//
// Parameters
//   IBUF_DEPTH  FIFO entries (>= 1, any integer)
//   HAZARD_EN   1 = insert load-use bubbles, 0 = never stall on hazards
//   CNT_W       width of bubble_cnt
//
// Ports
//   clk, rst_          clock, synchronous active-high reset
//   flush, stall       from EX: discard everything / hold output register
//   if_valid/if_ready  handshake toward IF (if_pc, if_instr carry payload)
//   id_valid, id_pc    registered instruction toward ID_EX
//   opcode, rd_addr, rs1_addr, rs2_addr, func3, func7, imm, illegal
//                      registered decode results
//   bubble_cnt         number of hazard bubbles inserted (saturating)
// ---------------------------------------------------------------------------
module id_stage_buf #(
    parameter int IBUF_DEPTH = 2,
    parameter int HAZARD_EN  = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instr,
    output logic             if_ready,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [6:0]       opcode,
    output logic [4:0]       rd_addr,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [31:0]      imm,
    output logic             illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int PTR_W    = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(IBUF_DEPTH + 1);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(IBUF_DEPTH);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // FIFO storage and bookkeeping
    logic [31:0]         r_pc_mem    [IBUF_DEPTH];
    logic [31:0]         r_instr_mem [IBUF_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_BITS-1:0] r_count;

    // Output register
    logic             r_id_valid;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_imm;
    logic             r_illegal;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic        w_push;
    logic        w_pop;
    logic        w_head_valid;
    logic [31:0] w_head_pc;
    logic [31:0] w_head_instr;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_hazard;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(IBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness depends only on occupancy: no push-while-full bypass even
    // when the head is being popped in the same cycle.
    assign if_ready     = !rst_ && (r_count < DEPTH_C);
    assign w_push       = if_valid && if_ready && !flush;
    assign w_head_valid = (r_count != '0);
    assign w_head_pc    = r_pc_mem[r_head];
    assign w_head_instr = r_instr_mem[r_head];

    // Immediate format, illegal flag and register usage of the head entry
    always_comb begin
        w_imm      = '0;
        w_illegal  = 1'b0;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        case (w_head_instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE:
                w_imm = {{20{w_head_instr[31]}}, w_head_instr[31:20]};
            OPC_STORE: begin
                w_imm      = {{20{w_head_instr[31]}}, w_head_instr[31:25],
                              w_head_instr[11:7]};
                w_rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm      = {{19{w_head_instr[31]}}, w_head_instr[31],
                              w_head_instr[7], w_head_instr[30:25],
                              w_head_instr[11:8], 1'b0};
                w_rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm      = {w_head_instr[31:12], 12'b0};
                w_rs1_used = 1'b0;
            end
            OPC_JAL: begin
                w_imm      = {{11{w_head_instr[31]}}, w_head_instr[31],
                              w_head_instr[19:12], w_head_instr[20],
                              w_head_instr[30:21], 1'b0};
                w_rs1_used = 1'b0;
            end
            OPC_OP:
                w_rs2_used = 1'b1;
            default:
                w_illegal = 1'b1;
        endcase
    end

    // Load in the output register whose result the head instruction needs
    assign w_hazard = (HAZARD_EN != 0) && r_id_valid
                   && (r_instr[6:0] == OPC_LOAD) && (r_instr[11:7] != 5'd0)
                   && w_head_valid
                   && ((w_rs1_used && (w_head_instr[19:15] == r_instr[11:7]))
                    || (w_rs2_used && (w_head_instr[24:20] == r_instr[11:7])));

    assign w_pop = !flush && !stall && w_head_valid && !w_hazard;

    // Storage array: no reset needed, occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]    <= if_pc;
            r_instr_mem[r_tail] <= if_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= next_ptr(r_tail);
            if (w_pop)
                r_head <= next_ptr(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_id_valid   <= 1'b0;
            r_id_pc      <= '0;
            r_instr      <= '0;
            r_imm        <= '0;
            r_illegal    <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_instr    <= '0;
            r_imm      <= '0;
            r_illegal  <= 1'b0;
        end else if (stall) begin
            r_id_valid <= r_id_valid;
        end else if (w_head_valid && !w_hazard) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= w_head_pc;
            r_instr    <= w_head_instr;
            r_imm      <= w_imm;
            r_illegal  <= w_illegal;
        end else if (w_head_valid) begin
            // Bubble: zeroed register also clears the load, so the hazard
            // resolves on the following cycle.
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_instr    <= '0;
            r_imm      <= '0;
            r_illegal  <= 1'b0;
            if (r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end else begin
            r_id_valid <= 1'b0;
        end
    end

    assign id_valid   = r_id_valid;
    assign id_pc      = r_id_pc;
    assign opcode     = r_instr[6:0];
    assign rd_addr    = r_instr[11:7];
    assign func3      = r_instr[14:12];
    assign rs1_addr   = r_instr[19:15];
    assign rs2_addr   = r_instr[24:20];
    assign func7      = r_instr[31:25];
    assign imm        = r_imm;
    assign illegal    = r_illegal;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_stage_buf.sv
module tb_id_stage_buf;

    logic        clk;
    logic        rst_;
    logic        flush;
    logic        stall;
    logic        if_valid;
    logic        if_valid2;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    // u1: depth 2, hazards on, 2-bit counter
    logic        u1_if_ready, u1_id_valid, u1_illegal;
    logic [31:0] u1_id_pc, u1_imm;
    logic [6:0]  u1_opcode, u1_func7;
    logic [4:0]  u1_rd, u1_rs1, u1_rs2;
    logic [2:0]  u1_func3;
    logic [1:0]  u1_bubble;

    // u2: depth 3, hazards off, 16-bit counter; fed only what u1 accepts
    logic        u2_if_ready, u2_id_valid, u2_illegal;
    logic [31:0] u2_id_pc, u2_imm;
    logic [6:0]  u2_opcode, u2_func7;
    logic [4:0]  u2_rd, u2_rs1, u2_rs2;
    logic [2:0]  u2_func3;
    logic [15:0] u2_bubble;

    assign if_valid2 = if_valid && u1_if_ready;

    id_stage_buf #(.IBUF_DEPTH(2), .HAZARD_EN(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_(rst_), .flush(flush), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(u1_if_ready), .id_valid(u1_id_valid), .id_pc(u1_id_pc),
        .opcode(u1_opcode), .rd_addr(u1_rd), .rs1_addr(u1_rs1),
        .rs2_addr(u1_rs2), .func3(u1_func3), .func7(u1_func7),
        .imm(u1_imm), .illegal(u1_illegal), .bubble_cnt(u1_bubble)
    );

    id_stage_buf #(.IBUF_DEPTH(3), .HAZARD_EN(0), .CNT_W(16)) u2 (
        .clk(clk), .rst_(rst_), .flush(flush), .stall(stall),
        .if_valid(if_valid2), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(u2_if_ready), .id_valid(u2_id_valid), .id_pc(u2_id_pc),
        .opcode(u2_opcode), .rd_addr(u2_rd), .rs1_addr(u2_rs1),
        .rs2_addr(u2_rs2), .func3(u2_func3), .func7(u2_func7),
        .imm(u2_imm), .illegal(u2_illegal), .bubble_cnt(u2_bubble)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        bit          chk_imm;
        bit          ill;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic hold    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Output register is re-presented while stalled; only fresh loads count.
    always @(posedge clk) hold <= stall;

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] pc,
                       input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im, input logic ill);
        logic [31:0] ins;
        ins = e.instr;
        $display("[TB] %s out pc=%h opcode=%h rd=%0d rs1=%0d rs2=%0d imm=%h illegal=%0b",
                 tag, pc, opc, rd, rs1, rs2, im, ill);
        chk({tag, " pc"}, pc, e.pc);
        chk({tag, " opcode"}, 32'(opc), 32'(ins[6:0]));
        chk({tag, " rd"}, 32'(rd), 32'(ins[11:7]));
        chk({tag, " rs1"}, 32'(rs1), 32'(ins[19:15]));
        chk({tag, " rs2"}, 32'(rs2), 32'(ins[24:20]));
        chk({tag, " func3"}, 32'(f3), 32'(ins[14:12]));
        chk({tag, " func7"}, 32'(f7), 32'(ins[31:25]));
        if (e.chk_imm)
            chk({tag, " imm"}, im, e.imm);
        chk({tag, " illegal"}, 32'(ill), 32'(e.ill));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (u1_id_valid === 1'b1 && !hold) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("[TB] FAIL u1 unexpected output: got pc %h required none", u1_id_pc);
            end else begin
                e = q1.pop_front();
                cmp("u1", e, u1_id_pc, u1_opcode, u1_rd, u1_rs1, u1_rs2,
                    u1_func3, u1_func7, u1_imm, u1_illegal);
            end
        end
        if (u2_id_valid === 1'b1 && !hold) begin
            if (q2.size() == 0) begin
                n_tests++; n_fail++;
                $display("[TB] FAIL u2 unexpected output: got pc %h required none", u2_id_pc);
            end else begin
                e = q2.pop_front();
                cmp("u2", e, u2_id_pc, u2_opcode, u2_rd, u2_rs1, u2_rs2,
                    u2_func3, u2_func7, u2_imm, u2_illegal);
            end
        end
    end

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] im, input bit ci, input bit ill);
        exp_t e;
        e.pc = pc; e.instr = instr; e.imm = im; e.chk_imm = ci; e.ill = ill;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    // Offer one instruction; called just after a rising edge, returns just
    // after the edge on which u1 accepted it.
    task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] im, input bit ill, input bit exp);
        bit acc;
        acc = 1'b0;
        if_valid = 1'b1; if_pc = pc; if_instr = instr;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = (u1_if_ready === 1'b1);
            if (acc && exp)
                expect_out(pc, instr, im, !ill, ill);
            cyc();
        end
        if_valid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL send timeout: pc %h not accepted, required accept", pc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_ = 1'b1; flush = 1'b0; stall = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_instr = '0;

        // Reset state
        idle(2);
        @(negedge clk);
        chk("reset if_ready u1", 32'(u1_if_ready), 32'd0);
        chk("reset if_ready u2", 32'(u2_if_ready), 32'd0);
        chk("reset id_valid", 32'(u1_id_valid), 32'd0);
        chk("reset id_pc", u1_id_pc, 32'd0);
        chk("reset imm", u1_imm, 32'd0);
        chk("reset bubble_cnt", 32'(u1_bubble), 32'd0);
        cyc();
        rst_ = 1'b0;
        idle(1);

        // ADDI x1,x2,-5: accepted at edge N, visible after edge N+1
        send(32'h100, 32'hFFB1_0093, 32'hFFFF_FFFB, 1'b0, 1'b1);
        @(negedge clk);
        chk("latency not yet valid", 32'(u1_id_valid), 32'd0);
        @(negedge clk);
        chk("latency valid", 32'(u1_id_valid), 32'd1);
        cyc();
        idle(2);

        // LW x5,0(x1) then ADD x6,x5,x7 back to back: one bubble on u1 only
        send(32'h104, 32'h0000_A283, 32'h0, 1'b0, 1'b1);
        send(32'h108, 32'h0072_8333, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("LW registered", 32'(u1_opcode), 32'h03);
        @(negedge clk);
        chk("bubble id_valid u1", 32'(u1_id_valid), 32'd0);
        chk("bubble_cnt u1", 32'(u1_bubble), 32'd1);
        chk("no bubble id_valid u2", 32'(u2_id_valid), 32'd1);
        cyc();
        idle(3);
        chk("bubble_cnt u2 after LW/ADD", 32'(u2_bubble), 32'd0);

        // Stall for 3 edges while IF offers JAL, ADDI, SW
        send(32'h200, 32'h0010_0193, 32'h1, 1'b0, 1'b1);
        cyc();
        stall = 1'b1;
        if_valid = 1'b1; if_pc = 32'h204; if_instr = 32'h0080_00EF;
        @(negedge clk);
        chk("stall1 if_ready", 32'(u1_if_ready), 32'd1);
        chk("stall1 id_pc", u1_id_pc, 32'h200);
        expect_out(32'h204, 32'h0080_00EF, 32'h8, 1'b1, 1'b0);
        cyc();
        if_pc = 32'h208; if_instr = 32'hFFF0_0213;
        @(negedge clk);
        chk("stall2 if_ready", 32'(u1_if_ready), 32'd1);
        chk("stall2 id_pc", u1_id_pc, 32'h200);
        expect_out(32'h208, 32'hFFF0_0213, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cyc();
        if_pc = 32'h20C; if_instr = 32'h0020_A223;
        @(negedge clk);
        chk("stall3 if_ready full", 32'(u1_if_ready), 32'd0);
        chk("stall3 id_pc", u1_id_pc, 32'h200);
        chk("stall3 id_valid", 32'(u1_id_valid), 32'd1);
        chk("stall3 imm", u1_imm, 32'h1);
        cyc();
        stall = 1'b0;
        send(32'h20C, 32'h0020_A223, 32'h4, 1'b0, 1'b1);
        idle(5);

        // Flush with 2 entries buffered, stall=1 and if_valid=1 together
        stall = 1'b1;
        send(32'h400, 32'h0010_0093, 32'h1, 1'b0, 1'b0);
        send(32'h404, 32'h0020_0113, 32'h2, 1'b0, 1'b0);
        if_valid = 1'b1; if_pc = 32'h408; if_instr = 32'h0030_0193;
        flush = 1'b1;
        cyc();
        flush = 1'b0; stall = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk("flush id_valid", 32'(u1_id_valid), 32'd0);
        chk("flush id_pc", u1_id_pc, 32'd0);
        chk("flush opcode", 32'(u1_opcode), 32'd0);
        chk("flush rs2", 32'(u1_rs2), 32'd0);
        chk("flush imm", u1_imm, 32'd0);
        chk("flush if_ready u1", 32'(u1_if_ready), 32'd1);
        chk("flush if_ready u2", 32'(u2_if_ready), 32'd1);
        chk("flush bubble_cnt kept", 32'(u1_bubble), 32'd1);
        cyc();
        idle(4);

        // BEQ x1,x2,-4 ; LUI x5,0x12345 ; illegal opcode 0x7F
        send(32'h500, 32'hFE20_8EE3, 32'hFFFF_FFFC, 1'b0, 1'b1);
        send(32'h504, 32'h1234_52B7, 32'h1234_5000, 1'b0, 1'b1);
        send(32'h508, 32'h0000_007F, 32'h0, 1'b1, 1'b1);
        idle(4);

        // Four more load-use pairs: 2-bit counter saturates at 3
        for (int k = 0; k < 4; k++) begin
            send(32'h600 + 32'(8 * k), 32'h0000_A283, 32'h0, 1'b0, 1'b1);
            send(32'h604 + 32'(8 * k), 32'h0072_8333, 32'h0, 1'b0, 1'b1);
        end
        idle(5);
        chk("bubble_cnt saturated", 32'(u1_bubble), 32'd3);
        chk("bubble_cnt u2 never counts", 32'(u2_bubble), 32'd0);

        // Reset mid-stream with entries buffered
        stall = 1'b1;
        send(32'h700, 32'h0010_0093, 32'h1, 1'b0, 1'b0);
        send(32'h704, 32'h0020_0113, 32'h2, 1'b0, 1'b0);
        if_valid = 1'b1; if_pc = 32'h708; if_instr = 32'h0030_0193;
        rst_ = 1'b1;
        @(negedge clk);
        chk("rst if_ready u1", 32'(u1_if_ready), 32'd0);
        chk("rst if_ready u2", 32'(u2_if_ready), 32'd0);
        cyc();
        @(negedge clk);
        chk("rst held if_ready", 32'(u1_if_ready), 32'd0);
        chk("rst id_valid", 32'(u1_id_valid), 32'd0);
        chk("rst id_pc", u1_id_pc, 32'd0);
        chk("rst rd", 32'(u1_rd), 32'd0);
        chk("rst bubble_cnt", 32'(u1_bubble), 32'd0);
        cyc();
        rst_ = 1'b0; stall = 1'b0; if_valid = 1'b0;
        idle(6);

        chk("u1 queue drained", 32'(q1.size()), 32'd0);
        chk("u2 queue drained", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
